gray_seq_gen: RTL and testbench
===============================

// Module: gray_seq_gen
// PURPOSE
//  Sequential Gray-code source. On a start pulse it emits a burst of num_beats
//  consecutive Gray codes from a binary base value, counting up or down,
//  over a valid/ready stream. It feeds the downstream Gray-to-binary decode
//  stage and the width-matched Gray pipelines. Single clock domain.
// PARAMETERS
//  size   10   code width in bits; counts wrap modulo 2**size
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     1-cycle request; sampled only in IDLE
//  dir        in   1     1 = count up, 0 = count down; latched at start
//  data_in    in   size  binary base value; latched at start
//  num_beats  in   size  burst length; latched at start; 0 = empty burst
//  abort      in   1     synchronous cancel of a burst in progress
//  out_valid  out  1     data_out holds a valid beat
//  out_ready  in   1     downstream accepts; transfer = out_valid & out_ready
//  data_out   out  size  Gray code of the current count (registered)
//  bin_out    out  size  binary value of the current count (registered)
//  out_last   out  1     high with the final beat of the burst
//  busy       out  1     high in RUN and DONE
//  done       out  1     1-cycle pulse after burst end or empty burst
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; all outputs and counters 0.
//  - States: IDLE, RUN, DONE.
//  - IDLE: start=1 with num_beats!=0 -> RUN. Latch bin=data_in, rem=num_beats,
//    dir. out_valid=1 and data_out=bin^(bin>>1) from the next cycle
//    (latency 1 cycle). start=1 with num_beats==0 -> DONE; no beat is emitted.
//  - RUN, transfer: bin <= bin+1 (dir=1) or bin-1 (dir=0), modulo 2**size;
//    rem <= rem-1. data_out/bin_out update in the same cycle. No transfer:
//    data_out, bin_out, out_last held stable.
//  - out_last = out_valid & (rem==1). A transfer with rem==1 -> DONE;
//    out_valid=0 next cycle.
//  - DONE: done=1 for exactly one cycle, then IDLE. done is never asserted
//    with out_valid.
//  - Wrap: up from 2**size-1 goes to 0 (Gray 100..0 -> 0). Down from 0 goes to
//    2**size-1 (Gray 0 -> 100..0). Adjacent beats always differ in exactly 1 bit.
//  - start outside IDLE is ignored. A start pulse in the DONE cycle is dropped.
//  - abort in RUN -> IDLE next cycle. out_valid, out_last=0. No done pulse.
//    abort has priority over a transfer in the same cycle: that beat is not
//    counted and is not accepted. abort in IDLE/DONE has no effect.
//  - rst_n low mid-burst clears immediately. The burst is not resumed.
//  - data_out/bin_out retain their last values in IDLE (they are not zeroed).
// STRUCTURE
//  - Package gray_pkg holds: typedef enum logic [1:0] {IDLE,RUN,DONE} gseq_state_t,
//    and function bin2gray(bin) = bin ^ (bin >> 1), parameterised by width.
//  - No sub-module: one state register plus bin/rem/dir registers.
//    data_out is registered from bin2gray(next_bin), so it is glitch-free.
// TESTING (size=4)
//  - start, base=3, len=3, up, ready=1 -> data_out 0010,0110,0111;
//    out_last on beat 3; done 1 cycle later.
//  - Up wrap: base=14, len=3 -> bin 14,15,0; Gray 1001,1000,0000.
//  - Down wrap: base=1, len=3, dir=0 -> bin 1,0,15; Gray 0001,0000,1000.
//  - Backpressure: ready=0 for 3 cycles mid-burst -> data_out/out_last held;
//    beat count unchanged.
//  - len=0 -> no out_valid; done pulses the cycle after start.
//    start during RUN is ignored.
//  - abort on beat 2 with ready=1 -> IDLE, no done; then reset mid-burst
//    -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/gray_pkg.sv
// ----------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the Gray-code sequence source.
//   gseq_state_t : burst controller states (IDLE, RUN, DONE)
//   bin2gray     : binary -> reflected Gray conversion; operands up to
//                  GRAY_MAX_W bits, zero-extended, so callers of any smaller
//                  width keep the low bits of the result.
// ----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gseq_state_t;

    // Zero-extension keeps the MSB of the narrow code equal to the binary MSB.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_gen.sv
// ----------------------------------------------------------------------------
// gray_seq_gen
// On a start pulse, emits a burst of num_beats consecutive Gray codes starting
// at binary base data_in, counting up (dir=1) or down (dir=0) modulo 2**size,
// over a valid/ready stream.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, dir          burst request (IDLE only), count direction
//   data_in, num_beats  base value and burst length (0 = empty burst)
//   abort               cancel a running burst, no done pulse
//   out_valid/out_ready stream handshake
//   data_out, bin_out   Gray / binary value of the current count
//   out_last            final beat of the burst
//   busy, done          RUN/DONE indicator, one-cycle end-of-burst pulse
// All outputs are registered.
// ----------------------------------------------------------------------------
module gray_seq_gen
    import gray_pkg::*;
#(
    parameter int size = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dir,
    input  logic [size-1:0] data_in,
    input  logic [size-1:0] num_beats,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] data_out,
    output logic [size-1:0] bin_out,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam logic [size-1:0] ZERO_C = {size{1'b0}};
    localparam logic [size-1:0] ONE_C  = {{(size-1){1'b0}}, 1'b1};

    gseq_state_t     state_r, state_nx_s;
    logic [size-1:0] bin_r, bin_nx_s;
    logic [size-1:0] rem_r, rem_nx_s;
    logic            dir_r, dir_nx_s;

    logic            out_valid_r, out_last_r, busy_r, done_r;
    logic [size-1:0] data_out_r;
    logic            valid_nx_s, last_nx_s, busy_nx_s, done_nx_s;
    logic [size-1:0] gray_nx_s;
    logic [GRAY_MAX_W-1:0] gray_wide_s;

    logic xfer_s;
    assign xfer_s = out_valid_r & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort wins over a same-cycle transfer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = (num_beats == ZERO_C) ? DONE : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx_s = IDLE;
                end else if (xfer_s && (rem_r == ONE_C)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Counter next values. The final transfer does not advance bin so that
    // data_out/bin_out keep showing the last emitted beat while idle.
    always_comb begin
        bin_nx_s = bin_r;
        rem_nx_s = rem_r;
        dir_nx_s = dir_r;
        case (state_r)
            IDLE: begin
                if (start && (num_beats != ZERO_C)) begin
                    bin_nx_s = data_in;
                    rem_nx_s = num_beats;
                    dir_nx_s = dir;
                end else begin
                    bin_nx_s = bin_r;
                end
            end
            RUN: begin
                if (abort) begin
                    rem_nx_s = ZERO_C;
                end else if (xfer_s) begin
                    rem_nx_s = rem_r - ONE_C;
                    if (rem_r != ONE_C) begin
                        bin_nx_s = dir_r ? (bin_r + ONE_C) : (bin_r - ONE_C);
                    end else begin
                        bin_nx_s = bin_r;
                    end
                end else begin
                    rem_nx_s = rem_r;
                end
            end
            DONE:    rem_nx_s = ZERO_C;
            default: rem_nx_s = ZERO_C;
        endcase
    end

    // Output next values, derived from the next state so outputs are flops.
    always_comb begin
        valid_nx_s  = (state_nx_s == RUN);
        last_nx_s   = valid_nx_s && (rem_nx_s == ONE_C);
        busy_nx_s   = (state_nx_s != IDLE);
        done_nx_s   = (state_nx_s == DONE);
        gray_wide_s = bin2gray({{(GRAY_MAX_W-size){1'b0}}, bin_nx_s});
        gray_nx_s   = gray_wide_s[size-1:0];
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r       <= ZERO_C;
            rem_r       <= ZERO_C;
            dir_r       <= 1'b0;
            data_out_r  <= ZERO_C;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            bin_r       <= bin_nx_s;
            rem_r       <= rem_nx_s;
            dir_r       <= dir_nx_s;
            data_out_r  <= gray_nx_s;
            out_valid_r <= valid_nx_s;
            out_last_r  <= last_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign data_out  = data_out_r;
    assign bin_out   = bin_r;

endmodule

// File: tb/tb_gray_seq_gen.sv
module tb_gray_seq_gen;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         dir;
    logic [W-1:0] data_in;
    logic [W-1:0] num_beats;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [W-1:0] bin_out;
    logic         out_last;
    logic         busy;
    logic         done;

    int checks_r   = 0;
    int failures_r = 0;

    gray_seq_gen #(.size(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir       (dir),
        .data_in   (data_in),
        .num_beats (num_beats),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .bin_out   (bin_out),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_r = checks_r + 1;
        if (obs !== exp_v) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expect a valid beat with the given Gray/binary value and last flag.
    task automatic expect_beat(input string tag, input logic [W-1:0] g, input logic [W-1:0] b,
                               input logic l);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_gray"},  32'(data_out),  32'(g));
        check_val({tag, "_bin"},   32'(bin_out),   32'(b));
        check_val({tag, "_last"},  32'(out_last),  32'(l));
        check_val({tag, "_done"},  32'(done),      32'd0);
    endtask

    // Expect the DONE cycle, then back to IDLE.
    task automatic expect_done(input string tag);
        check_val({tag, "_dvalid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_dpulse"}, 32'(done),      32'd1);
        check_val({tag, "_dbusy"},  32'(busy),      32'd1);
        @(negedge clk);
        check_val({tag, "_idone"},  32'(done),      32'd0);
        check_val({tag, "_ibusy"},  32'(busy),      32'd0);
    endtask

    task automatic do_start(input logic [W-1:0] base, input logic [W-1:0] len, input logic d);
        start     = 1'b1;
        data_in   = base;
        num_beats = len;
        dir       = d;
        @(negedge clk);
        start     = 1'b0;
        data_in   = 4'b0000;
        num_beats = 4'b0000;
    endtask

    // Run a three-beat burst with ready held high and check every beat.
    task automatic burst3(input string tag, input logic [W-1:0] base, input logic d,
                          input logic [W-1:0] g0, input logic [W-1:0] g1, input logic [W-1:0] g2,
                          input logic [W-1:0] b1, input logic [W-1:0] b2);
        out_ready = 1'b1;
        do_start(base, 4'd3, d);
        expect_beat({tag, "_b1"}, g0, base, 1'b0);
        @(negedge clk);
        expect_beat({tag, "_b2"}, g1, b1, 1'b0);
        @(negedge clk);
        expect_beat({tag, "_b3"}, g2, b2, 1'b1);
        @(negedge clk);
        expect_done(tag);
        check_val({tag, "_hold"}, 32'(data_out), 32'(g2));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        dir       = 1'b1;
        data_in   = 4'b0000;
        num_beats = 4'b0000;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_gray",  32'(data_out),  32'd0);
        check_val("rst_bin",   32'(bin_out),   32'd0);
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_done",  32'(done),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic up burst, up wrap, down wrap.
        burst3("up",    4'd3,  1'b1, 4'b0010, 4'b0110, 4'b0111, 4'd4, 4'd5);
        burst3("upwr",  4'd14, 1'b1, 4'b1001, 4'b1000, 4'b0000, 4'd15, 4'd0);
        burst3("dnwr",  4'd1,  1'b0, 4'b0001, 4'b0000, 4'b1000, 4'd0, 4'd15);

        // Backpressure for three cycles; a start during RUN is ignored.
        out_ready = 1'b1;
        do_start(4'd5, 4'd3, 1'b1);
        expect_beat("bp_b1", 4'b0111, 4'd5, 1'b0);
        @(negedge clk);
        expect_beat("bp_b2", 4'b0101, 4'd6, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start     = (i == 0) ? 1'b1 : 1'b0;
            data_in   = 4'd12;
            num_beats = 4'd9;
            dir       = 1'b0;
            @(negedge clk);
            expect_beat("bp_hold", 4'b0101, 4'd6, 1'b0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        expect_beat("bp_b3", 4'b0100, 4'd7, 1'b1);
        @(negedge clk);
        expect_done("bp");

        // Empty burst.
        do_start(4'd7, 4'd0, 1'b1);
        expect_done("empty");

        // Abort on beat 2 while ready is high: no done, beat not counted.
        do_start(4'd8, 4'd4, 1'b1);
        expect_beat("ab_b1", 4'b1100, 4'd8, 1'b0);
        @(negedge clk);
        expect_beat("ab_b2", 4'b1101, 4'd9, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("ab_valid", 32'(out_valid), 32'd0);
        check_val("ab_last",  32'(out_last),  32'd0);
        check_val("ab_busy",  32'(busy),      32'd0);
        check_val("ab_done",  32'(done),      32'd0);
        check_val("ab_bin",   32'(bin_out),   32'd9);
        @(negedge clk);
        check_val("ab_done2", 32'(done),      32'd0);

        // Reset mid-burst clears outputs without waiting for a clock edge.
        do_start(4'd2, 4'd5, 1'b1);
        expect_beat("rs_b1", 4'b0011, 4'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("rs_valid", 32'(out_valid), 32'd0);
        check_val("rs_gray",  32'(data_out),  32'd0);
        check_val("rs_bin",   32'(bin_out),   32'd0);
        check_val("rs_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rs_noresume", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
